// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator: buffers two previous rows and emits every fully
// populated 3x3 window of a raster-order frame with a registered valid and position.
module window_gen_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [DATA_WIDTH-1:0]         pixel_in,
  input  logic                          pixel_valid,
  output logic [9*DATA_WIDTH-1:0]       window_out,
  output logic                          window_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [DATA_WIDTH-1:0] linebuf1 [IMG_WIDTH];  // row r-1
  logic [DATA_WIDTH-1:0] linebuf2 [IMG_WIDTH];  // row r-2
  logic [DATA_WIDTH-1:0] win_sr   [9];
  logic [DATA_WIDTH-1:0] next_win [9];
  logic [9*DATA_WIDTH-1:0] next_flat;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          emit;

  assign accept   = enable && pixel_valid && !clear;
  assign col_last = (col_cnt == COL_LAST);
  assign row_last = (row_cnt == ROW_LAST);
  // Only windows whose three columns all come from the current rows are emitted.
  assign emit     = accept && (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    next_flat = '0;
    for (int r = 0; r < 3; r++) begin
      next_win[r*3]     = win_sr[r*3+1];
      next_win[r*3 + 1] = win_sr[r*3+2];
      next_win[r*3 + 2] = '0;
    end
    next_win[2] = linebuf2[col_cnt];
    next_win[5] = linebuf1[col_cnt];
    next_win[8] = pixel_in;
    for (int k = 0; k < 9; k++) begin
      next_flat[k*DATA_WIDTH +: DATA_WIDTH] = next_win[k];
    end
  end

  // NOTE: storage arrays are not reset; counters gate their use, so reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (accept) begin
      linebuf1[col_cnt] <= pixel_in;
      linebuf2[col_cnt] <= linebuf1[col_cnt];
      win_sr            <= next_win;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      window_out   <= '0;
      window_valid <= 1'b0;
      out_row      <= '0;
      out_col      <= '0;
      frame_done   <= 1'b0;
    end else if (clear) begin
      col_cnt      <= '0;
      row_cnt      <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      window_valid <= emit;
      frame_done   <= emit && row_last && col_last;
      if (accept) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
      end
      if (emit) begin
        window_out <= next_flat;
        out_row    <= row_cnt - RW'(2);
        out_col    <= col_cnt - CW'(2);
      end
    end
  end

endmodule
